// File: rtl/rv32_types.sv
// Shared types for the RV32 memory stage: memory-op encoding, pipeline buffers and FSM states.
package rv32_types;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_t;

    typedef struct packed {
        mem_op_t    mem_op;
        logic       register_wb;
        logic [4:0] rd;
    } decoded_instr_t;

    typedef struct packed {
        decoded_instr_t decoded_instr;
        logic [31:0]    instr;
        logic [31:0]    alu_result;
        logic [31:0]    store_data;
        logic           valid;
    } ex_mem_buffer_t;

    typedef struct packed {
        decoded_instr_t decoded_instr;
        logic [31:0]    instr;
        logic [31:0]    wb_result;
        logic [31:0]    mem_addr;
        logic           valid;
        logic           misaligned;
    } mem_wb_buffer_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_fsm_t;

    function automatic logic is_mem_op(mem_op_t op);
        return op != NONE;
    endfunction

    function automatic logic is_store(mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/rv32_mem_stage_if.sv
// Data-memory port of the memory stage: valid/ready request channel plus a response channel.
interface rv32_mem_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );
endinterface

// File: rtl/rv32_store_align.sv
// Byte-lane steering for stores and alignment check. MEM_MISALIGN_TRAP_EN enables the
// misaligned flag; without it the flag is tied low and accesses use the lanes as computed.
module rv32_store_align
    import rv32_types::*;
(
    input  mem_op_t     i_mem_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_store_data;
        case (i_mem_op)
            SB: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SH: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
            end
            SW:      o_wstrb = 4'b1111;
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        o_misaligned = 1'b0;
        case (i_mem_op)
            LH, LHU, SH: o_misaligned = i_addr_lo[0];
            LW, SW:      o_misaligned = |i_addr_lo;
            default:     ;
        endcase
    end
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: issues loads/stores over the dmem port, stalls while a response is
// outstanding, registers the writeback buffer. Optional MEM_MISALIGN_TRAP_EN (see rv32_store_align).
module rv32_mem_stage
    import rv32_types::*;
#(
    parameter int RSP_TIMEOUT = 0,
    parameter int TIMEOUT_W   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  ex_mem_buffer_t   ex_mem_buff,
    input  logic             flush,
    output mem_wb_buffer_t   mem_wb_buff,
    output logic [31:0]      mem_data,
    output logic [31:0]      mem_bypass,
    output logic             mem_stall,
    output logic             bus_error,
    rv32_mem_stage_if.master dmem
);

    localparam bit                   LP_TO_EN   = (RSP_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] LP_TO_LAST = TIMEOUT_W'(RSP_TIMEOUT - 1);

    mem_fsm_t             r_state, w_next;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_kill, r_bus_error;
    mem_wb_buffer_t       r_mem_wb, w_wb_nxt, w_full;
    logic [31:0]          r_mem_data;
    mem_op_t              w_op;
    logic                 w_memop, w_mis, w_go, w_trap, w_plain, w_kill, w_timeout;
    logic                 w_req, w_stall, w_done, w_to;
    logic [3:0]           w_wstrb;
    logic [31:0]          w_wdata;

    assign w_op      = ex_mem_buff.decoded_instr.mem_op;
    assign w_memop   = ex_mem_buff.valid && is_mem_op(w_op);
    assign w_go      = w_memop && !flush && !w_mis;
    assign w_trap    = w_memop && !flush && w_mis;
    assign w_plain   = ex_mem_buff.valid && !is_mem_op(w_op) && !flush;
    assign w_kill    = r_kill || flush;
    assign w_timeout = LP_TO_EN && (r_cnt == LP_TO_LAST);

    rv32_store_align u_align (
        .i_mem_op     (w_op),
        .i_addr_lo    (ex_mem_buff.alu_result[1:0]),
        .i_store_data (ex_mem_buff.store_data),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_misaligned (w_mis)
    );

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_stall = 1'b0;
        w_done  = 1'b0;
        w_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (dmem.dmem_req_ready) w_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the timeout cycle wins over the timeout.
                if (dmem.dmem_rsp_valid) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_to   = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_full               = '0;
        w_full.decoded_instr = ex_mem_buff.decoded_instr;
        w_full.instr         = ex_mem_buff.instr;
        w_full.wb_result     = ex_mem_buff.alu_result;
        w_full.mem_addr      = ex_mem_buff.alu_result;
        w_full.valid         = 1'b1;
        w_wb_nxt             = '0;
        if (r_state == IDLE && w_trap) begin
            w_wb_nxt.misaligned = 1'b1;
            w_wb_nxt.mem_addr   = ex_mem_buff.alu_result;
        end else if ((r_state == IDLE && w_plain) || (w_done && !w_kill)) begin
            w_wb_nxt = w_full;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_bus_error <= 1'b0;
            r_mem_wb    <= '0;
            r_mem_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= (LP_TO_EN && r_state == WAIT_RSP && w_next == WAIT_RSP) ? r_cnt + 1'b1 : '0;
            r_kill      <= (w_next == WAIT_RSP) && (r_kill || (r_state == WAIT_RSP && flush));
            r_bus_error <= w_to;
            r_mem_wb    <= w_wb_nxt;
            // Store acknowledges and discarded responses leave the load word untouched.
            if (w_done && !w_kill && !is_store(w_op)) r_mem_data <= dmem.dmem_rsp_data;
        end
    end

    assign dmem.dmem_req_valid = w_req && resetn;
    assign dmem.dmem_addr      = {ex_mem_buff.alu_result[31:2], 2'b00};
    assign dmem.dmem_we        = is_store(w_op);
    assign dmem.dmem_wstrb     = w_wstrb;
    assign dmem.dmem_wdata     = w_wdata;

    assign mem_stall   = w_stall && resetn;
    assign mem_wb_buff = r_mem_wb;
    assign mem_data    = r_mem_data;
    assign mem_bypass  = ex_mem_buff.alu_result;
    assign bus_error   = r_bus_error;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Randomized bench for rv32_mem_stage with a transaction-level expectation model.
module tb_rv32_mem_stage;
    import rv32_types::*;

    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           flush = 1'b0;
    ex_mem_buffer_t ex;
    mem_wb_buffer_t wb;
    logic [31:0]    mdata, byp;
    logic           stall, berr;

    rv32_mem_stage_if bus ();

    rv32_mem_stage #(.RSP_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_mem_buff (ex),
        .flush       (flush),
        .mem_wb_buff (wb),
        .mem_data    (mdata),
        .mem_bypass  (byp),
        .mem_stall   (stall),
        .bus_error   (berr),
        .dmem        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model state: expected registered outputs and expected combinational outputs this cycle
    mem_wb_buffer_t m_wb, n_wb;
    logic [31:0]    m_data, n_data;
    logic           m_berr, n_berr;
    logic           e_stall, e_req, e_we, e_chk_wdata;
    logic [31:0]    e_bypass, e_addr, e_wdata;
    logic [3:0]     e_wstrb;
    logic           chk_en = 1'b0;

    // per-transaction observations
    int          s_stall_cnt, s_req_cnt;
    logic        s_unstable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_we;

    mem_op_t ops [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_lanes(mem_op_t op, logic [1:0] a);
        int off, sz;
        logic [3:0] r;
        off = 0; sz = 0; r = 4'b0000;
        if (op == SB) begin off = int'(a); sz = 1; end
        if (op == SH) begin off = (int'(a) / 2) * 2; sz = 2; end
        if (op == SW) begin off = 0; sz = 4; end
        for (int b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + sz);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(mem_op_t op, logic [31:0] sd);
        logic [31:0] r;
        r = sd;
        for (int b = 0; b < 4; b++) begin
            if (op == SB) r[b*8 +: 8] = sd[7:0];
            if (op == SH) r[b*8 +: 8] = sd[(b % 2)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic m_misaligned(mem_op_t op, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return ((op == LH || op == LHU || op == SH) && (a % 2 != 0)) ||
               ((op == LW || op == SW) && (a % 4 != 0));
`else
        return (op == NONE) && (a != a);
`endif
    endfunction

    function automatic ex_mem_buffer_t mk_ex(mem_op_t op, logic [31:0] alu, logic [31:0] sd);
        ex_mem_buffer_t e;
        e.decoded_instr.mem_op      = op;
        e.decoded_instr.register_wb = 1'($urandom);
        e.decoded_instr.rd          = 5'($urandom);
        e.instr                     = $urandom;
        e.alu_result                = alu;
        e.store_data                = sd;
        e.valid                     = 1'b1;
        return e;
    endfunction

    function automatic mem_wb_buffer_t full(ex_mem_buffer_t e);
        mem_wb_buffer_t w;
        w               = '0;
        w.decoded_instr = e.decoded_instr;
        w.instr         = e.instr;
        w.wb_result     = e.alu_result;
        w.mem_addr      = e.alu_result;
        w.valid         = 1'b1;
        return w;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 128'(stall), 128'(e_stall));
            chk("req_valid", 128'(bus.dmem_req_valid), 128'(e_req));
            chk("bypass", 128'(byp), 128'(e_bypass));
            chk("mem_wb_buff", 128'(wb), 128'(m_wb));
            chk("mem_data", 128'(mdata), 128'(m_data));
            chk("bus_error", 128'(berr), 128'(m_berr));
            if (e_req) begin
                chk("addr", 128'(bus.dmem_addr), 128'(e_addr));
                chk("we", 128'(bus.dmem_we), 128'(e_we));
                chk("wstrb", 128'(bus.dmem_wstrb), 128'(e_wstrb));
                if (e_chk_wdata) chk("wdata", 128'(bus.dmem_wdata), 128'(e_wdata));
            end
        end
    end

    task automatic s_clear();
        s_stall_cnt = 0; s_req_cnt = 0; s_unstable = 1'b0;
        s_addr = '0; s_wdata = '0; s_wstrb = '0; s_we = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (stall) s_stall_cnt++;
        if (bus.dmem_req_valid) begin
            if (s_req_cnt == 0) begin
                s_addr = bus.dmem_addr; s_wstrb = bus.dmem_wstrb; s_wdata = bus.dmem_wdata; s_we = bus.dmem_we;
            end else if (bus.dmem_addr != s_addr || bus.dmem_wstrb != s_wstrb || bus.dmem_wdata != s_wdata) begin
                s_unstable = 1'b1;
            end
            s_req_cnt++;
        end
        @(posedge clk);
        #1;
        m_wb = n_wb; m_data = n_data; m_berr = n_berr;
    endtask

    task automatic prep();
        s_clear();
        flush = 1'b0;
        bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = $urandom;
        e_stall = 1'b0; e_req = 1'b0; e_chk_wdata = 1'b0; e_we = 1'b0;
        n_wb = '0; n_data = m_data; n_berr = 1'b0;
    endtask

    task automatic nonmem(input logic [31:0] alu, input logic fl);
        prep();
        ex = mk_ex(NONE, alu, $urandom);
        flush = fl;
        e_bypass = alu;
        if (!fl) n_wb = full(ex);
        cyc();
        flush = 1'b0;
    endtask

    task automatic idle_cycle(input logic late_rsp);
        prep();
        ex = mk_ex(ops[$urandom_range(0, 7)], $urandom, $urandom);
        ex.valid = 1'b0;
        e_bypass = ex.alu_result;
        bus.dmem_rsp_valid = late_rsp;
        cyc();
        bus.dmem_rsp_valid = 1'b0;
    endtask

    // flush_j < 0: flushed before acceptance; flush_j > 0: flush from wait cycle flush_j on
    task automatic memtxn(input mem_op_t op, input logic [31:0] alu, input logic [31:0] sd,
                          input int rdy_wait, input int lat, input int flush_j, input logic [31:0] rdata);
        logic killed, st;
        prep();
        ex = mk_ex(op, alu, sd);
        st = (op == SB) || (op == SH) || (op == SW);
        e_bypass = alu;
        if (flush_j < 0) begin
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            return;
        end
        if (m_misaligned(op, alu)) begin
            n_wb.misaligned = 1'b1;
            n_wb.mem_addr = alu;
            cyc();
            return;
        end
        e_req = 1'b1; e_stall = 1'b1;
        e_addr = alu & ~32'h3; e_we = st; e_wstrb = m_lanes(op, alu[1:0]);
        e_wdata = m_wdata(op, sd); e_chk_wdata = st;
        for (int i = 0; i <= rdy_wait; i++) begin
            bus.dmem_req_ready = (i == rdy_wait);
            bus.dmem_rsp_valid = 1'($urandom);
            bus.dmem_rsp_data = $urandom;
            cyc();
        end
        bus.dmem_req_ready = 1'b0;
        e_req = 1'b0;
        killed = 1'b0;
        for (int j = 1; j <= 64; j++) begin
            bus.dmem_rsp_valid = (j == lat);
            bus.dmem_rsp_data = (j == lat) ? rdata : $urandom;
            flush = (flush_j > 0) && (j >= flush_j);
            if (flush) killed = 1'b1;
            if (j == lat) begin
                e_stall = 1'b0;
                if (!killed) n_wb = full(ex);
                if (!killed && !st) n_data = rdata;
                cyc();
                break;
            end else if (TO != 0 && j == TO) begin
                e_stall = 1'b0;
                n_berr = 1'b1;
                cyc();
                break;
            end else begin
                e_stall = 1'b1;
                cyc();
            end
        end
        bus.dmem_rsp_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        int k, lat, fj, r;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        ex = mk_ex(LW, 32'h0000_0100, 32'h0);
        bus.dmem_req_ready = 1'b1; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_req_valid", 128'(bus.dmem_req_valid), 128'(0));
        chk("reset_wb", 128'(wb), 128'(0));
        chk("reset_mem_data", 128'(mdata), 128'(0));
        chk("reset_bus_error", 128'(berr), 128'(0));
        ex.valid = 1'b0;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        m_wb = '0; m_data = '0; m_berr = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_chk_wdata = 1'b0; e_we = 1'b0; e_bypass = ex.alu_result;
        e_addr = '0; e_wdata = '0; e_wstrb = '0;
        chk_en = 1'b1;

        nonmem(32'h0000_0010, 1'b0);
        chk("add_wb_result", 128'(wb.wb_result), 128'(32'h10));
        chk("add_valid", 128'(wb.valid), 128'(1));
        chk("add_no_stall", 128'(s_stall_cnt), 128'(0));

        memtxn(LW, 32'h0000_1004, 32'h0, 0, 3, 0, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 128'(s_stall_cnt), 128'(3));
        chk("lw_mem_data", 128'(mdata), 128'(32'hDEAD_BEEF));
        chk("lw_mem_addr", 128'(wb.mem_addr), 128'(32'h0000_1004));

        memtxn(SB, 32'h0000_2003, 32'h0000_00AB, 0, 2, 0, 32'h5555_5555);
        chk("sb_addr", 128'(s_addr), 128'(32'h0000_2000));
        chk("sb_wstrb", 128'(s_wstrb), 128'(4'b1000));
        chk("sb_wdata", 128'(s_wdata), 128'(32'hABAB_ABAB));
        chk("sb_we", 128'(s_we), 128'(1));
        chk("sb_mem_data_kept", 128'(mdata), 128'(32'hDEAD_BEEF));

        memtxn(SH, 32'h0000_3002, 32'h0000_BEEF, 2, 1, 0, 32'h0);
        chk("held_req_cycles", 128'(s_req_cnt), 128'(3));
        chk("held_req_stable", 128'(s_unstable), 128'(0));
        chk("sh_wstrb", 128'(s_wstrb), 128'(4'b1100));

        memtxn(LW, 32'h0000_4000, 32'h0, 0, 3, 2, 32'h1234_5678);
        chk("flush_valid", 128'(wb.valid), 128'(0));
        chk("flush_register_wb", 128'(wb.decoded_instr.register_wb), 128'(0));
        chk("flush_mem_data", 128'(mdata), 128'(32'hDEAD_BEEF));

        memtxn(LW, 32'h0000_5000, 32'h0, 0, 10, 0, 32'h0);
        chk("timeout_stall_cycles", 128'(s_stall_cnt), 128'(4));
        chk("timeout_bus_error", 128'(berr), 128'(1));
        idle_cycle(1'b1);
        chk("timeout_pulse_end", 128'(berr), 128'(0));
        chk("late_rsp_ignored", 128'(mdata), 128'(32'hDEAD_BEEF));

        memtxn(LW, 32'h0000_1002, 32'h0, 0, 1, 0, 32'h0BAD_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_no_req", 128'(s_req_cnt), 128'(0));
        chk("mis_flag", 128'(wb.misaligned), 128'(1));
`else
        chk("mis_trunc_addr", 128'(s_addr), 128'(32'h0000_1000));
        chk("mis_flag_tied", 128'(wb.misaligned), 128'(0));
`endif

        repeat (200) begin
            k = $urandom_range(0, 9);
            if (k < 3) nonmem($urandom, ($urandom_range(0, 5) == 0));
            else if (k == 3) idle_cycle(1'($urandom));
            else begin
                lat = $urandom_range(1, 5);
                r = $urandom_range(0, 9);
                fj = (r == 0) ? -1 : (r == 1) ? $urandom_range(1, lat) : 0;
                memtxn(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom_range(0, 2), lat, fj, $urandom);
            end
        end

        chk_en = 1'b0;
        prep();
        ex = mk_ex(LW, 32'h0000_6000, 32'h0);
        #2;
        chk("pre_async_req", 128'(bus.dmem_req_valid), 128'(1));
        resetn = 1'b0;
        #1;
        chk("async_req_drop", 128'(bus.dmem_req_valid), 128'(0));
        chk("async_stall_drop", 128'(stall), 128'(0));
        chk("async_wb_clear", 128'(wb), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
